// File: rtl/tl_phase_sched.sv
// Four-phase intersection scheduler (A, A-left, B, B-left) with round-robin hand-off.
// Define TL_ALL_RED_EN to add an all-red CLEAR interval after each yellow.
module tl_phase_sched #(
    parameter int MIN_GREEN  = 2,
    parameter int MAX_GREEN  = 6,
    parameter int YELLOW_CYC = 1,
    parameter int CLEAR_CYC  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [3:0] grant
);

`ifdef TL_ALL_RED_EN
    typedef enum logic [1:0] {GREEN, YELLOW, CLEAR} state_t;
`else
    typedef enum logic [1:0] {GREEN, YELLOW} state_t;
    logic unused_clear_cyc;
    assign unused_clear_cyc = ^4'(CLEAR_CYC);
`endif

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_LEFT   = 2'b10;
    localparam logic [1:0] L_RED    = 2'b11;

    state_t     state, state_n;
    logic [1:0] cur_ph, cur_n;
    logic [1:0] nxt_ph, nxt_n;
    logic [3:0] cnt, cnt_n;

    logic [3:0] req;
    logic [4:0] g;
    logic       own_req;
    logic       other_req;
    logic       go_exit;
    logic [1:0] pick;

    assign req       = {Tbl, Tb, Tal, Ta};
    assign g         = {1'b0, cnt} + 5'd1;
    assign own_req   = req[cur_ph];
    assign other_req = |(req & ~(4'b0001 << cur_ph));
    assign go_exit   = other_req && (g >= 5'(MIN_GREEN))
                    && (!own_req || g >= 5'(MAX_GREEN));

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        pick = cur_ph;
        for (int k = 3; k >= 1; k--) begin
            if (req[cur_ph + 2'(k)]) pick = cur_ph + 2'(k);
        end
    end

    function automatic logic [7:0] lights(input state_t s, input logic [1:0] p);
        logic [1:0] la, lb;
        logic [3:0] gr;
        la = L_RED;
        lb = L_RED;
        gr = 4'b0000;
        if (s == GREEN) begin
            gr = 4'b0001 << p;
            unique case (p)
                2'd0: la = L_GREEN;
                2'd1: la = L_LEFT;
                2'd2: lb = L_GREEN;
                default: lb = L_LEFT;
            endcase
        end else if (s == YELLOW) begin
            if (p[1]) lb = L_YELLOW;
            else      la = L_YELLOW;
        end
        return {la, lb, gr};
    endfunction

    always_comb begin
        state_n = state;
        cur_n   = cur_ph;
        nxt_n   = nxt_ph;
        cnt_n   = cnt;
        unique case (state)
            GREEN: begin
                if (go_exit) begin
                    state_n = YELLOW;
                    cnt_n   = 4'd0;
                    nxt_n   = pick;
                end else if (cnt != 4'd15) begin
                    cnt_n = cnt + 4'd1;
                end
            end
            YELLOW: begin
                if (cnt == 4'(YELLOW_CYC - 1)) begin
                    cnt_n = 4'd0;
`ifdef TL_ALL_RED_EN
                    state_n = CLEAR;
`else
                    state_n = GREEN;
                    cur_n   = nxt_ph;
`endif
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
`ifdef TL_ALL_RED_EN
            CLEAR: begin
                if (cnt == 4'(CLEAR_CYC - 1)) begin
                    state_n = GREEN;
                    cur_n   = nxt_ph;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
`endif
            default: begin
                state_n = GREEN;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // Lights are registered from the next-state values, so they track state exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= GREEN;
            cur_ph           <= 2'd0;
            nxt_ph           <= 2'd0;
            cnt              <= 4'd0;
            {La, Lb, grant}  <= {L_GREEN, L_RED, 4'b0001};
        end else begin
            state            <= state_n;
            cur_ph           <= cur_n;
            nxt_ph           <= nxt_n;
            cnt              <= cnt_n;
            {La, Lb, grant}  <= lights(state_n, cur_n);
        end
    end

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed and randomized bench for tl_phase_sched against a phase-level model.
// Honours TL_ALL_RED_EN the same way the design does.
module tb_tl_phase_sched;

    localparam int MIN_G = 2;
    localparam int MAX_G = 6;
    localparam int YEL   = 1;
    localparam int CLR   = 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       Ta, Tal, Tb, Tbl;
    logic [1:0] La, Lb;
    logic [3:0] grant;

    int tests = 0;
    int fails = 0;

    // Model: mode 0=green, 1=yellow, 2=all-red; m_g is the green cycle number.
    int m_mode, m_cur, m_nxt, m_g, m_left;

    tl_phase_sched #(
        .MIN_GREEN (MIN_G),
        .MAX_GREEN (MAX_G),
        .YELLOW_CYC(YEL),
        .CLEAR_CYC (CLR)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .Ta   (Ta),
        .Tal  (Tal),
        .Tb   (Tb),
        .Tbl  (Tbl),
        .La   (La),
        .Lb   (Lb),
        .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_out();
        logic [1:0] la, lb;
        logic [3:0] gr;
        la = 2'b11;
        lb = 2'b11;
        gr = 4'b0000;
        if (m_mode == 0) begin
            gr = 4'(1 << m_cur);
            if (m_cur == 0) la = 2'b00;
            if (m_cur == 1) la = 2'b10;
            if (m_cur == 2) lb = 2'b00;
            if (m_cur == 3) lb = 2'b10;
        end else if (m_mode == 1) begin
            if (m_cur >= 2) lb = 2'b01;
            else            la = 2'b01;
        end
        return {la, lb, gr};
    endfunction

    task automatic model_edge(input bit rst, input logic [3:0] r);
        bit other;
        bit found;
        if (rst) begin
            m_mode = 0; m_cur = 0; m_nxt = 0; m_g = 1; m_left = 0;
            return;
        end
        if (m_mode == 0) begin
            other = 0;
            for (int k = 1; k < 4; k++) if (r[(m_cur + k) % 4]) other = 1;
            if (other && m_g >= MIN_G && (!r[m_cur] || m_g >= MAX_G)) begin
                found = 0;
                for (int k = 1; k < 4; k++) begin
                    if (!found && r[(m_cur + k) % 4]) begin
                        m_nxt = (m_cur + k) % 4;
                        found = 1;
                    end
                end
                m_mode = 1;
                m_left = YEL;
            end else if (m_g < 16) begin
                m_g++;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
`ifdef TL_ALL_RED_EN
                if (m_mode == 1) begin
                    m_mode = 2;
                    m_left = CLR;
                end else begin
                    m_mode = 0; m_cur = m_nxt; m_g = 1;
                end
`else
                m_mode = 0; m_cur = m_nxt; m_g = 1;
`endif
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: La/Lb/grant=%b required %b", tag, got, exp);
        end
    endtask

    // Check against the model at the falling edge, then advance one clock.
    task automatic step(input string tag);
        chk(tag, {La, Lb, grant}, model_out());
        @(posedge clk);
        model_edge(reset, {Tbl, Tb, Tal, Ta});
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step("rst0");
        step("rst1");
        reset = 1'b0;
    endtask

    logic [7:0] seq2 [$];
    int         al_seen, bl_seen, wait_n;
    bit         hit;

    initial begin
        reset = 1'b1;
        {Ta, Tal, Tb, Tbl} = 4'b0000;
        model_edge(1'b1, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Idle: A holds green indefinitely.
        do_reset();
        chk("reset_state", {La, Lb, grant}, 8'b00_11_0001);
        for (int i = 0; i < 20; i++) step("idle");
        chk("idle_end", {La, Lb, grant}, 8'b00_11_0001);

        // Single B request: exact hand-off timeline.
        do_reset();
        Tb = 1'b1;
        seq2 = {8'b00_11_0001, 8'b00_11_0001, 8'b01_11_0000};
`ifdef TL_ALL_RED_EN
        seq2.push_back(8'b11_11_0000);
`endif
        seq2.push_back(8'b11_00_0100);
        foreach (seq2[i]) begin
            chk("b_handoff", {La, Lb, grant}, seq2[i]);
            step("b_handoff_m");
        end

        // A and B held: alternation at max green.
        do_reset();
        {Ta, Tal, Tb, Tbl} = 4'b0101;
        for (int i = 0; i < 40; i++) step("ab_alt");

        // All four held: full round-robin, left-turn light codes.
        do_reset();
        {Ta, Tal, Tb, Tbl} = 4'b1111;
        al_seen = 0;
        bl_seen = 0;
`ifdef TL_ALL_RED_EN
        for (int i = 0; i < 32; i++) begin
`else
        for (int i = 0; i < 28; i++) begin
`endif
            if ({La, Lb, grant} == 8'b10_11_0010) al_seen++;
            if ({La, Lb, grant} == 8'b11_10_1000) bl_seen++;
            step("rr4");
        end
        chk("al_cycles", 8'(al_seen), 8'(MAX_G));
        chk("bl_cycles", 8'(bl_seen), 8'(MAX_G));
        chk("rr4_back_a", {La, Lb, grant}, 8'b00_11_0001);

        // Reset during yellow discards the pending hand-off to B.
        do_reset();
        {Ta, Tal, Tb, Tbl} = 4'b0010;
        hit = 0;
        wait_n = 0;
        while (!hit && wait_n < 20) begin
            if (La == 2'b01) hit = 1;
            else begin
                step("pre_yel");
                wait_n++;
            end
        end
        chk("yellow_reached", {7'd0, hit}, 8'd1);
        reset = 1'b1;
        step("rst_yel");
        reset = 1'b0;
        chk("rst_yel_a", {La, Lb, grant}, 8'b00_11_0001);
        step("post_rst1");
        chk("post_rst_hold", {La, Lb, grant}, 8'b00_11_0001);
        step("post_rst2");
        chk("post_rst_yel", {La, Lb, grant}, 8'b01_11_0000);

        // Randomized requests with long holds and occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) {Ta, Tal, Tb, Tbl} = 4'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            step("rand");
        end
        reset = 1'b0;
        step("rand_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
